// File: rtl/vfp_config_axi_master.sv
// AXI4-Lite initiator: single write/read commands in, one response per command out.
// Optional busy-cycle abort enabled by defining VFP_CFG_TIMEOUT_EN.
module vfp_config_axi_master #(
  parameter int unsigned C_vfpConfig_DATA_WIDTH = 32,
  parameter int unsigned C_vfpConfig_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES         = 1024
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic                                  cmd_write,
  input  logic [C_vfpConfig_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_vfpConfig_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_vfpConfig_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                                  rsp_valid,
  output logic [C_vfpConfig_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                            rsp_resp,
  output logic                                  rsp_timeout,
  output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_awaddr,
  output logic [2:0]                            vfpconfig_awprot,
  output logic                                  vfpconfig_awvalid,
  input  logic                                  vfpconfig_awready,
  output logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_wdata,
  output logic [C_vfpConfig_DATA_WIDTH/8-1:0]   vfpconfig_wstrb,
  output logic                                  vfpconfig_wvalid,
  input  logic                                  vfpconfig_wready,
  input  logic [1:0]                            vfpconfig_bresp,
  input  logic                                  vfpconfig_bvalid,
  output logic                                  vfpconfig_bready,
  output logic [C_vfpConfig_ADDR_WIDTH-1:0]     vfpconfig_araddr,
  output logic [2:0]                            vfpconfig_arprot,
  output logic                                  vfpconfig_arvalid,
  input  logic                                  vfpconfig_arready,
  input  logic [C_vfpConfig_DATA_WIDTH-1:0]     vfpconfig_rdata,
  input  logic [1:0]                            vfpconfig_rresp,
  input  logic                                  vfpconfig_rvalid,
  output logic                                  vfpconfig_rready
);

  localparam int unsigned DW = C_vfpConfig_DATA_WIDTH;
  localparam int unsigned AW = C_vfpConfig_ADDR_WIDTH;
  localparam int unsigned SW = C_vfpConfig_DATA_WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;
  logic            accept, expired, waiting, aw_pend, w_pend;

  assign cmd_ready = (state_q == StIdle) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign aw_pend   = awvalid_q && !vfpconfig_awready;
  assign w_pend    = wvalid_q && !vfpconfig_wready;

`ifdef VFP_CFG_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  // Fires on the edge that closes the TIMEOUT_CYCLES-th busy cycle.
  assign expired = (state_q != StIdle) && (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cnt_q <= '0;
    end else if (state_q != StIdle && cnt_q < CntW'(TIMEOUT_CYCLES)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`else
  logic unused_timeout_cycles;
  assign expired               = 1'b0;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d       = state_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    araddr_d      = araddr_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    waiting       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && cmd_write) begin
          awaddr_d  = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StWrReq;
        end else if (accept) begin
          araddr_d  = cmd_addr;
          arvalid_d = 1'b1;
          state_d   = StRdReq;
        end
      end
      StWrReq: begin
        // AW and W retire independently; move on once neither is pending.
        awvalid_d = aw_pend;
        wvalid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end else begin
          waiting = 1'b1;
        end
      end
      StWrResp: begin
        if (vfpconfig_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = vfpconfig_bresp;
          state_d     = StIdle;
        end else begin
          waiting = 1'b1;
        end
      end
      StRdReq: begin
        if (vfpconfig_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdResp;
        end else begin
          waiting = 1'b1;
        end
      end
      StRdResp: begin
        if (vfpconfig_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = vfpconfig_rdata;
          rsp_resp_d  = vfpconfig_rresp;
          state_d     = StIdle;
        end else begin
          waiting = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A handshake completing on the expiry edge takes priority over the abort.
    if (expired && waiting) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      state_d       = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      araddr_q      <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
    end else begin
      state_q       <= state_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      araddr_q      <= araddr_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
    end
  end

  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_resp          = rsp_resp_q;
  assign rsp_timeout       = rsp_timeout_q;
  assign vfpconfig_awaddr  = awaddr_q;
  assign vfpconfig_awprot  = 3'b000;
  assign vfpconfig_awvalid = awvalid_q;
  assign vfpconfig_wdata   = wdata_q;
  assign vfpconfig_wstrb   = wstrb_q;
  assign vfpconfig_wvalid  = wvalid_q;
  assign vfpconfig_bready  = bready_q;
  assign vfpconfig_araddr  = araddr_q;
  assign vfpconfig_arprot  = 3'b000;
  assign vfpconfig_arvalid = arvalid_q;
  assign vfpconfig_rready  = rready_q;

endmodule

// File: tb/tb_vfp_config_axi_master.sv
// Bench for vfp_config_axi_master: delay-programmable slave, register-map model, per-cycle compare.
module tb_vfp_config_axi_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  vfp_config_axi_master #(
    .C_vfpConfig_DATA_WIDTH(32),
    .C_vfpConfig_ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .vfpconfig_awaddr(awaddr), .vfpconfig_awprot(awprot), .vfpconfig_awvalid(awvalid),
    .vfpconfig_awready(awready),
    .vfpconfig_wdata(wdata), .vfpconfig_wstrb(wstrb), .vfpconfig_wvalid(wvalid),
    .vfpconfig_wready(wready),
    .vfpconfig_bresp(bresp), .vfpconfig_bvalid(bvalid), .vfpconfig_bready(bready),
    .vfpconfig_araddr(araddr), .vfpconfig_arprot(arprot), .vfpconfig_arvalid(arvalid),
    .vfpconfig_arready(arready),
    .vfpconfig_rdata(rdata), .vfpconfig_rresp(rresp), .vfpconfig_rvalid(rvalid),
    .vfpconfig_rready(rready)
  );

  typedef struct packed {
    logic        wr;
    logic        to;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  int checks = 0, failures = 0, cyc = 0;
  exp_t exp_q[$];
  int acc_cyc[$], rsp_cyc[$];
  logic [31:0] mmem [16];   // reference register map
  logic [31:0] smem [16];   // slave storage, written only by bus beats
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_resp = '0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_n = 0, w_n = 0, ar_n = 0, ar_hi_n = 0, rsp_n = 0;
  logic [7:0]  cap_aw = '0, cap_ar = '0;
  logic [31:0] cap_wd = '0;
  logic [3:0]  cap_ws = '0;
  logic        have_aw = 1'b0, have_w = 1'b0, expect_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave: each ready/valid rises after its programmed number of wait cycles.
  initial begin
    int aw_w, w_w, b_w, ar_w, r_w;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
      end else begin
        awready = awvalid && (aw_w >= aw_dly);
        aw_w    = (awvalid && !awready) ? aw_w + 1 : 0;
        wready  = wvalid && (w_w >= w_dly);
        w_w     = (wvalid && !wready) ? w_w + 1 : 0;
        bvalid  = bready && (b_w >= b_dly);
        b_w     = (bready && !bvalid) ? b_w + 1 : 0;
        bresp   = (cap_aw >= 8'h40) ? 2'b10 : 2'b00;
        arready = arvalid && (ar_w >= ar_dly);
        ar_w    = (arvalid && !arready) ? ar_w + 1 : 0;
        rvalid  = rready && (r_w >= r_dly);
        r_w     = (rready && !rvalid) ? r_w + 1 : 0;
        rresp   = (cap_ar >= 8'h40) ? 2'b10 : 2'b00;
        rdata   = (cap_ar >= 8'h40) ? 32'h0 : smem[cap_ar[5:2]];
      end
    end
  end

  // Monitor, model and compare, sampled mid-cycle.
  initial begin
    exp_t e;
    logic p_rst, p_aw, p_w, p_ar;
    logic [7:0] p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    int chk_req_cyc;
    logic chk_req_wr;
    p_rst = 1; p_aw = 0; p_w = 0; p_ar = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0;
    chk_req_cyc = -1; chk_req_wr = 0;
    forever begin
      @(negedge clk);
      chk("awprot", awprot, 0);
      chk("arprot", arprot, 0);
      chk("bus_overlap", (awvalid || wvalid || bready) && (arvalid || rready), 0);
      if (reset) begin
        chk("cmd_ready_in_reset", cmd_ready, 0);
        exp_q.delete();
        if (acc_cyc.size() > rsp_cyc.size()) void'(acc_cyc.pop_back());
        aw_n = 0; w_n = 0; ar_n = 0; have_aw = 0; have_w = 0;
      end else begin
        if (!p_rst && !(rsp_valid && rsp_timeout)) begin
          if (p_aw) chk("awvalid_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
          if (p_w)  chk("wvalid_hold", {wvalid, wdata}, {1'b1, p_wdata});
          if (p_ar) chk("arvalid_hold", {arvalid, araddr}, {1'b1, p_araddr});
        end
        if (arvalid) ar_hi_n++;
        if (awvalid && awready) begin aw_n++; cap_aw = awaddr; have_aw = 1; end
        if (wvalid && wready) begin w_n++; cap_wd = wdata; cap_ws = wstrb; have_w = 1; end
        if (have_aw && have_w) begin
          if (cap_aw < 8'h40)
            for (int b = 0; b < 4; b++)
              if (cap_ws[b]) smem[cap_aw[5:2]][8*b +: 8] = cap_wd[8*b +: 8];
          have_aw = 0; have_w = 0;
        end
        if (arvalid && arready) begin ar_n++; cap_ar = araddr; end
        if (chk_req_cyc == cyc) begin
          if (chk_req_wr) chk("wr_req_valids", {awvalid, wvalid}, 2'b11);
          else            chk("rd_req_valid", arvalid, 1);
        end
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("rsp_timeout", rsp_timeout, e.to);
            if (!e.to && e.wr) chk("wr_beats", {aw_n, w_n}, {32'd1, 32'd1});
            if (!e.to && !e.wr) chk("rd_beats", ar_n, 1);
          end
          aw_n = 0; w_n = 0; ar_n = 0;
          rsp_cyc.push_back(cyc);
          last_rdata = rsp_rdata;
          last_resp = rsp_resp;
          rsp_n++;
        end
        if (cmd_valid && cmd_ready) begin
          e.wr = cmd_write;
          e.to = expect_to;
          e.resp = (expect_to || cmd_addr >= 8'h40) ? 2'b10 : 2'b00;
          e.rdata = 32'h0;
          if (!expect_to && cmd_addr < 8'h40) begin
            if (cmd_write) begin
              for (int b = 0; b < 4; b++)
                if (cmd_wstrb[b]) mmem[cmd_addr[5:2]][8*b +: 8] = cmd_wdata[8*b +: 8];
            end else begin
              e.rdata = mmem[cmd_addr[5:2]];
            end
          end
          exp_q.push_back(e);
          acc_cyc.push_back(cyc);
          chk_req_cyc = cyc + 1;
          chk_req_wr = cmd_write;
          ar_hi_n = 0;
        end
      end
      p_rst = reset;
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_w  = wvalid && !wready;   p_wdata = wdata;
      p_ar = arvalid && !arready; p_araddr = araddr;
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    logic ok;
    int n;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("rsp_wait_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic int lat();
    return rsp_cyc[rsp_cyc.size()-1] - acc_cyc[rsp_cyc.size()-1];
  endfunction

  initial begin
    int k, n, r0;
    for (int i = 0; i < 16; i++) begin mmem[i] = '0; smem[i] = '0; end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}, 0);
    chk("reset_rsp", {rsp_rdata, rsp_resp}, 0);
    chk("reset_addr_data", {awaddr, araddr, wdata, wstrb}, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // Write with ready slave, then read back.
    issue(1, 8'h08, 32'h0000_00A5, 4'hF); wait_done();
    chk("t1_latency", lat(), 3);
    chk("t1_resp", last_resp, 2'b00);
    issue(0, 8'h08, 32'h0, 4'h0); wait_done();
    chk("t1_rd_latency", lat(), 3);
    chk("t1_readback", last_rdata, 32'h0000_00A5);

    // awready three cycles behind wvalid; then partial-strobe overwrite.
    aw_dly = 3;
    issue(1, 8'h0C, 32'h1122_3344, 4'hF); wait_done();
    chk("t2_latency", lat(), 6);
    aw_dly = 0;
    issue(1, 8'h0C, 32'hAABB_CCDD, 4'b0101); wait_done();
    issue(0, 8'h0C, 32'h0, 4'h0); wait_done();
    chk("t2_strobe_readback", last_rdata, 32'h11BB_33DD);

    // rvalid five cycles after rready.
    r_dly = 5;
    issue(0, 8'h08, 32'h0, 4'h0); wait_done();
    chk("t3_latency", lat(), 8);
    chk("t3_rdata", last_rdata, 32'h0000_00A5);
    r_dly = 0;

    // Back-to-back write then read with cmd_valid held.
    k = acc_cyc.size();
    issue(1, 8'h10, 32'hCAFE_0001, 4'hF);
    issue(0, 8'h10, 32'h0, 4'h0);
    wait_done();
    chk("t4_b2b_accept", acc_cyc[k+1], rsp_cyc[k]);
    chk("t4_rdata", last_rdata, 32'hCAFE_0001);

    // Error responses from an unmapped address.
    issue(1, 8'h44, 32'h1234_5678, 4'hF); wait_done();
    chk("t5_wr_err", last_resp, 2'b10);
    issue(0, 8'h44, 32'h0, 4'h0); wait_done();
    chk("t5_rd_err", {last_resp, last_rdata}, {2'b10, 32'h0});

    // Reset while waiting for the write response.
    b_dly = 10;
    r0 = rsp_n;
    issue(1, 8'h30, 32'h5A5A_5A5A, 4'hF);
    n = 0;
    while (!bready && n < 50) begin @(negedge clk); n++; end
    chk("t6_reached_wr_resp", bready, 1);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("t6_after_reset", {bready, rsp_valid, awvalid, wvalid, cmd_ready}, 5'b00001);
    chk("t6_rsp_regs_cleared", {rsp_rdata, rsp_resp}, 0);
    chk("t6_no_rsp", rsp_n, r0);
    b_dly = 0;
    @(posedge clk);
    #1;
    issue(0, 8'h30, 32'h0, 4'h0); wait_done();
    chk("t6_next_cmd", {last_resp, last_rdata}, {2'b00, 32'h5A5A_5A5A});

`ifdef VFP_CFG_TIMEOUT_EN
    // Slave never accepts the read address.
    ar_dly = 1000;
    expect_to = 1;
    issue(0, 8'h08, 32'h0, 4'h0);
    expect_to = 0;
    wait_done();
    chk("t7_latency", lat(), 17);
    chk("t7_arvalid_cycles", ar_hi_n, 16);
    chk("t7_resp", last_resp, 2'b10);
    ar_dly = 0;
    issue(0, 8'h08, 32'h0, 4'h0); wait_done();
    chk("t7_recover", last_rdata, 32'h0000_00A5);
`endif

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
